// File: rtl/seven_segment_scan_receiver.sv
// seven_segment_scan_receiver
//   Recovers four hex digits and their decimal points from a multiplexed,
//   active-low four-digit seven-segment scan. Used for loopback checks of the
//   display driver and for sniffing an external display bus.
//
//   A strobe is captured only after STABLE_CYCLES identical synchronized
//   samples. A captured glyph is decoded by exact match against the hex font.
//   A digit that has not been freshly captured for TIMEOUT_CYCLES is marked stale.
//
// Ports
//   clk_100MHz     in   system clock
//   reset          in   synchronous, active-high reset
//   anodes[3:0]    in   AN3..AN0, active low, bit k selects digit k
//   cathodes[7:0]  in   [6:0] = CG..CA, [7] = DP, all active low
//   v3..v0[3:0]    out  recovered hex value per digit
//   dp[3:0]        out  recovered decimal point per digit (1 = lit)
//   digit_valid    out  bit k set while v_k holds a fresh legal capture
//   frame_valid    out  AND of digit_valid
//   update         out  one-cycle pulse when a digit value is written
//   pattern_error  out  one-cycle pulse when a stable strobe carries an illegal glyph
module seven_segment_scan_receiver #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [3:0] anodes,
  input  logic [7:0] cathodes,
  output logic [3:0] v3,
  output logic [3:0] v2,
  output logic [3:0] v1,
  output logic [3:0] v0,
  output logic [3:0] dp,
  output logic [3:0] digit_valid,
  output logic       frame_valid,
  output logic       update,
  output logic       pattern_error
);

  localparam int SC_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_CYCLES);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] QUALIFY  = 2'd1;
  localparam logic [1:0] CAPTURED = 2'd2;

  // Returns {legal, hex}; only the exact font patterns are legal.
  function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b0;
    case (seg)
      7'h3F: r = {1'b1, 4'h0};
      7'h06: r = {1'b1, 4'h1};
      7'h5B: r = {1'b1, 4'h2};
      7'h4F: r = {1'b1, 4'h3};
      7'h66: r = {1'b1, 4'h4};
      7'h6D: r = {1'b1, 4'h5};
      7'h7D: r = {1'b1, 4'h6};
      7'h07: r = {1'b1, 4'h7};
      7'h7F: r = {1'b1, 4'h8};
      7'h6F: r = {1'b1, 4'h9};
      7'h77: r = {1'b1, 4'hA};
      7'h7C: r = {1'b1, 4'hB};
      7'h39: r = {1'b1, 4'hC};
      7'h5E: r = {1'b1, 4'hD};
      7'h79: r = {1'b1, 4'hE};
      7'h71: r = {1'b1, 4'hF};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_one_hot(input logic [3:0] a);
    return (a != 4'b0) && ((a & (a - 4'd1)) == 4'b0);
  endfunction

  function automatic logic [1:0] onehot_index(input logic [3:0] a);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (a[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [SC_W-1:0] sat_inc_stable(input logic [SC_W-1:0] c);
    return (c >= SC_MAX) ? SC_MAX : c + SC_W'(1);
  endfunction

  function automatic logic [TO_W-1:0] sat_inc_timeout(input logic [TO_W-1:0] c);
    return (c >= TO_MAX) ? TO_MAX : c + TO_W'(1);
  endfunction

  // ---- p0/p1: two-flop synchronizer, p2: previous synced sample ----
  logic [11:0] s_p0;
  logic [11:0] s_p1;
  logic [11:0] s_p2;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      s_p0 <= '1;
      s_p1 <= '1;
      s_p2 <= '1;
    end else begin
      s_p0 <= {anodes, cathodes};
      s_p1 <= s_p0;
      s_p2 <= s_p1;
    end
  end

  logic [3:0] act_p1;
  logic [6:0] seg_p1;
  logic       dp_bit_p1;
  logic       one_hot_p1;
  logic [1:0] idx_p1;
  logic       same_p1;
  logic [4:0] glyph_p1;

  assign act_p1     = ~s_p1[11:8];
  assign seg_p1     = ~s_p1[6:0];
  assign dp_bit_p1  = ~s_p1[7];
  assign one_hot_p1 = is_one_hot(act_p1);
  assign idx_p1     = onehot_index(act_p1);
  assign same_p1    = (s_p1 == s_p2);
  assign glyph_p1   = glyph_decode(seg_p1);

  // ---- stability qualification FSM ----
  logic [1:0]      state_q;
  logic [1:0]      state_next;
  logic [SC_W-1:0] cnt_q;
  logic [SC_W-1:0] cnt_next;
  logic            cap_vld_p2;

  always_comb begin
    state_next = state_q;
    cnt_next   = cnt_q;
    cap_vld_p2 = 1'b0;
    case (state_q)
      IDLE: begin
        if (one_hot_p1) begin
          state_next = QUALIFY;
          cnt_next   = SC_W'(1);
        end
      end
      QUALIFY: begin
        if (same_p1) begin
          cnt_next = sat_inc_stable(cnt_q);
          if (cnt_next == SC_MAX) begin
            cap_vld_p2 = 1'b1;
            state_next = CAPTURED;
          end
        end else if (one_hot_p1) begin
          cnt_next = SC_W'(1);
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      CAPTURED: begin
        // Hold (count stays saturated) until the strobe changes; a change
        // is handled exactly as a fresh strobe arriving in IDLE.
        if (!same_p1) begin
          if (one_hot_p1) begin
            state_next = QUALIFY;
            cnt_next   = SC_W'(1);
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_next;
      cnt_q   <= cnt_next;
    end
  end

  // ---- p3: capture, staleness timers and output registers ----
  logic [3:0]      val_q [4];
  logic [TO_W-1:0] tmr_q [4];
  logic            blank_p2;

  assign blank_p2 = (seg_p1 == 7'h00);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        val_q[k] <= 4'h0;
        tmr_q[k] <= '0;
      end
      dp            <= 4'b0;
      digit_valid   <= 4'b0;
      update        <= 1'b0;
      pattern_error <= 1'b0;
    end else begin
      update        <= 1'b0;
      pattern_error <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        tmr_q[k] <= sat_inc_timeout(tmr_q[k]);
        if (sat_inc_timeout(tmr_q[k]) == TO_MAX) digit_valid[k] <= 1'b0;
      end
      // Written after the timeout loop so a capture overrides a same-cycle timeout.
      if (cap_vld_p2) begin
        if (glyph_p1[4]) begin
          val_q[idx_p1]       <= glyph_p1[3:0];
          dp[idx_p1]          <= dp_bit_p1;
          digit_valid[idx_p1] <= 1'b1;
          tmr_q[idx_p1]       <= '0;
          update              <= 1'b1;
        end else if (blank_p2) begin
          dp[idx_p1]          <= dp_bit_p1;
          digit_valid[idx_p1] <= 1'b0;
        end else begin
          digit_valid[idx_p1] <= 1'b0;
          pattern_error       <= 1'b1;
        end
      end
    end
  end

  assign v0          = val_q[0];
  assign v1          = val_q[1];
  assign v2          = val_q[2];
  assign v3          = val_q[3];
  assign frame_valid = &digit_valid;

endmodule

// File: tb/tb_seven_segment_scan_receiver.sv
// tb_seven_segment_scan_receiver
//   Directed bench for seven_segment_scan_receiver with STABLE_CYCLES=8 and
//   TIMEOUT_CYCLES=64. Inputs are driven 1 time unit after a rising edge and
//   outputs are sampled at the same offset, so "tick(n)" advances exactly n edges.
module tb_seven_segment_scan_receiver;

  localparam int SC = 8;
  localparam int TO = 64;

  logic       clk_100MHz;
  logic       reset;
  logic [3:0] anodes;
  logic [7:0] cathodes;
  logic [3:0] v3, v2, v1, v0;
  logic [3:0] dp;
  logic [3:0] digit_valid;
  logic       frame_valid;
  logic       update;
  logic       pattern_error;

  int checks;
  int errors;

  seven_segment_scan_receiver #(
    .STABLE_CYCLES (SC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .reset        (reset),
    .anodes       (anodes),
    .cathodes     (cathodes),
    .v3           (v3),
    .v2           (v2),
    .v1           (v1),
    .v0           (v0),
    .dp           (dp),
    .digit_valid  (digit_valid),
    .frame_valid  (frame_valid),
    .update       (update),
    .pattern_error(pattern_error)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Active-low cathode byte for a given decimal point and segment pattern.
  function automatic logic [7:0] cath(input logic dpb, input logic [6:0] seg);
    return ~{dpb, seg};
  endfunction

  initial begin
    logic [6:0] font [16];
    logic [3:0] digs [4];
    logic [3:0] dps;
    int upd_cnt;
    int err_cnt;
    logic fv_seen;

    font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    anodes   = 4'hF;
    cathodes = 8'hFF;

    // Reset state
    tick(3);
    check("rst_v", {16'h0, v3, v2, v1, v0}, 32'h0);
    check("rst_dp", {28'h0, dp}, 32'h0);
    check("rst_dv", {28'h0, digit_valid}, 32'h0);
    check("rst_fv", {31'h0, frame_valid}, 32'h0);
    check("rst_upd", {31'h0, update}, 32'h0);
    check("rst_perr", {31'h0, pattern_error}, 32'h0);
    reset = 1'b0;

    // Digit 0 shows '5', dp off: capture exactly SC+2 edges later
    anodes   = 4'b1110;
    cathodes = cath(1'b0, 7'h6D);
    tick(SC + 1);
    check("t1_early_upd", {31'h0, update}, 32'h0);
    check("t1_early_dv", {28'h0, digit_valid}, 32'h0);
    tick(1);
    check("t1_upd", {31'h0, update}, 32'h1);
    check("t1_v0", {28'h0, v0}, 32'h5);
    check("t1_dp", {28'h0, dp}, 32'h0);
    check("t1_dv", {28'h0, digit_valid}, 32'h1);
    check("t1_fv", {31'h0, frame_valid}, 32'h0);
    tick(1);
    check("t1_upd_drop", {31'h0, update}, 32'h0);
    upd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      upd_cnt += int'(update);
    end
    check("t1_no_repeat", upd_cnt, 0);

    // Digit 3 shows 'b' with dp lit, then an illegal glyph (segment a only)
    anodes   = 4'b0111;
    cathodes = cath(1'b1, 7'h7C);
    tick(SC + 1);
    check("t4_pre_upd", {31'h0, update}, 32'h0);
    tick(1);
    check("t4_upd", {31'h0, update}, 32'h1);
    check("t4_v3", {28'h0, v3}, 32'hB);
    check("t4_dp", {28'h0, dp}, 32'h8);
    check("t4_dv", {28'h0, digit_valid}, 32'h9);
    tick(1);
    cathodes = cath(1'b0, 7'h01);
    tick(SC + 2);
    check("t4_perr", {31'h0, pattern_error}, 32'h1);
    check("t4_perr_upd", {31'h0, update}, 32'h0);
    check("t4_dv_clr", {28'h0, digit_valid}, 32'h1);
    check("t4_v3_kept", {28'h0, v3}, 32'hB);
    check("t4_dp_kept", {28'h0, dp}, 32'h8);
    tick(1);
    check("t4_perr_drop", {31'h0, pattern_error}, 32'h0);

    // Blank digit 1 with dp lit: dp recorded, no value, no pulses
    anodes   = 4'b1101;
    cathodes = cath(1'b1, 7'h00);
    tick(SC + 2);
    check("blank_upd", {31'h0, update}, 32'h0);
    check("blank_perr", {31'h0, pattern_error}, 32'h0);
    check("blank_dp", {28'h0, dp}, 32'hA);
    check("blank_dv", {28'h0, digit_valid}, 32'h1);
    check("blank_v1", {28'h0, v1}, 32'h0);

    // Digit 0 was captured 53 edges ago; it goes stale at exactly 64
    tick(10);
    check("to0_before", {28'h0, digit_valid}, 32'h1);
    tick(1);
    check("to0_after", {28'h0, digit_valid}, 32'h0);
    check("to0_v0_kept", {28'h0, v0}, 32'h5);

    // Strobes never held long enough: no capture of any kind
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    upd_cnt = 0;
    err_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      anodes   = ~(4'b0001 << (i % 4));
      cathodes = cath(1'b0, (i % 3 == 2) ? 7'h01 : font[i]);
      for (int j = 0; j < SC - 1; j++) begin
        tick(1);
        upd_cnt += int'(update);
        err_cnt += int'(pattern_error);
      end
    end
    anodes   = 4'hF;
    cathodes = 8'hFF;
    for (int j = 0; j < 14; j++) begin
      tick(1);
      upd_cnt += int'(update);
      err_cnt += int'(pattern_error);
    end
    check("t3_no_upd", upd_cnt, 0);
    check("t3_no_perr", err_cnt, 0);
    check("t3_dv", {28'h0, digit_valid}, 32'h0);
    check("t3_v", {16'h0, v3, v2, v1, v0}, 32'h0);

    // Loopback of a display driver showing A,3,7,F with dp on digits 2 and 0
    digs    = '{4'hF, 4'h7, 4'h3, 4'hA};
    dps     = 4'b0101;
    fv_seen = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 4; k++) begin
        anodes   = ~(4'b0001 << k);
        cathodes = cath(dps[k], font[digs[k]]);
        for (int j = 0; j < 12; j++) begin
          tick(1);
          if (frame_valid) fv_seen = 1'b1;
        end
      end
    end
    check("t2_fv_seen", {31'h0, fv_seen}, 32'h1);
    check("t2_fv", {31'h0, frame_valid}, 32'h1);
    check("t2_v", {16'h0, v3, v2, v1, v0}, 32'hA37F);
    check("t2_dp", {28'h0, dp}, 32'h5);

    // Digit 2 recaptured as '2', then two anodes active forever
    anodes   = 4'b1011;
    cathodes = cath(1'b0, 7'h5B);
    tick(SC + 1);
    check("t5_pre_upd", {31'h0, update}, 32'h0);
    tick(1);
    check("t5_upd", {31'h0, update}, 32'h1);
    check("t5_v2", {28'h0, v2}, 32'h2);
    check("t5_dp", {28'h0, dp}, 32'h1);
    anodes  = 4'b0011;
    upd_cnt = 0;
    for (int j = 0; j < TO - 1; j++) begin
      tick(1);
      upd_cnt += int'(update);
    end
    check("t5_dv2_before", {31'h0, digit_valid[2]}, 32'h1);
    tick(1);
    check("t5_dv2_after", {31'h0, digit_valid[2]}, 32'h0);
    check("t5_v2_kept", {28'h0, v2}, 32'h2);
    check("t5_no_upd", upd_cnt, 0);
    check("t5_fv", {31'h0, frame_valid}, 32'h0);

    // Reset at stability count SC-1, then a full recapture
    anodes   = 4'b1110;
    cathodes = cath(1'b0, 7'h79);
    tick(SC + 1);
    check("t6_pre_upd", {31'h0, update}, 32'h0);
    reset = 1'b1;
    tick(1);
    check("t6_rst_upd", {31'h0, update}, 32'h0);
    check("t6_rst_v", {16'h0, v3, v2, v1, v0}, 32'h0);
    check("t6_rst_dp", {28'h0, dp}, 32'h0);
    check("t6_rst_dv", {28'h0, digit_valid}, 32'h0);
    check("t6_rst_perr", {31'h0, pattern_error}, 32'h0);
    reset = 1'b0;
    tick(SC + 1);
    check("t6_early_upd", {31'h0, update}, 32'h0);
    check("t6_early_dv", {28'h0, digit_valid}, 32'h0);
    tick(1);
    check("t6_upd", {31'h0, update}, 32'h1);
    check("t6_v0", {28'h0, v0}, 32'hE);
    check("t6_dv", {28'h0, digit_valid}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
